tdm_demux_1x8: RTL and testbench

//  Receive end of the 8-lane time-division link: takes a serial slot stream with a frame

---
 rtl/tdm_demux_1x8_if.sv | 27 ++
 rtl/tdm_demux_1x8.sv | 172 +++++++++++++++++
 tb/tb_tdm_demux_1x8.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_1x8_if.sv
// Bus bundle for the TDM 1x8 receive demux: slot stream in, frame word plus status out.
// The slave modport is the demux view; the master modport is the source/consumer view.
interface tdm_demux_1x8_if #(
    parameter int unsigned SLOT_W = 1
);
    logic                  in_valid;
    logic [SLOT_W-1:0]     in_data;
    logic                  in_sync;
    logic [8*SLOT_W-1:0]   out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [2:0]            lane_sel;
    logic                  locked;
    logic                  sync_err;
    logic                  overrun;
    logic                  par_err;

    modport master (
        output in_valid, in_data, in_sync, out_ready,
        input  out_data, out_valid, lane_sel, locked, sync_err, overrun, par_err
    );

    modport slave (
        input  in_valid, in_data, in_sync, out_ready,
        output out_data, out_valid, lane_sel, locked, sync_err, overrun, par_err
    );
endinterface

// File: rtl/tdm_demux_1x8.sv
// Receive end of the 8-lane TDM link: frame lock, slot routing into a registered word, handshake.
// Define PARITY_CHECK_EN for a 9-slot frame whose last slot carries per-bit even parity.
module tdm_demux_1x8 #(
    parameter int unsigned SLOT_W        = 1,
    parameter int unsigned SYNC_LOSS_MAX = 3
) (
    input  logic               clk,
    input  logic               rst,
    tdm_demux_1x8_if.slave     bus
);
    localparam int unsigned LANES  = 8;
    localparam int unsigned WORD_W = LANES * SLOT_W;
    localparam int unsigned LANE_W = 4;
    localparam int unsigned MISS_W = 4;
`ifdef PARITY_CHECK_EN
    localparam int unsigned NSLOT  = 9;
`else
    localparam int unsigned NSLOT  = 8;
`endif
    localparam logic [LANE_W-1:0] LAST_SLOT = LANE_W'(NSLOT - 1);
    localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(SYNC_LOSS_MAX);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [LANE_W-1:0]   r_lane,     w_lane_nxt;
    logic [MISS_W-1:0]   r_miss,     w_miss_nxt;
    logic [WORD_W-1:0]   r_shadow,   w_shadow_nxt;
    logic [WORD_W-1:0]   r_out_data, w_out_data_nxt;
    logic                r_out_valid, w_out_valid_nxt;
    logic                r_sync_err, w_sync_err_nxt;
    logic                r_overrun,  w_overrun_nxt;
    logic [MISS_W-1:0]   w_miss_inc;
    logic                w_frame_ok;

`ifdef PARITY_CHECK_EN
    logic                r_par_err,  w_par_err_nxt;
    logic [SLOT_W-1:0]   w_parity;

    // Even parity per bit position over the eight stored data slots.
    always_comb begin
        w_parity = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_parity = w_parity ^ r_shadow[i*SLOT_W +: SLOT_W];
        end
    end
`endif

    assign w_miss_inc = r_miss + MISS_W'(1);

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HUNT;
            r_lane      <= '0;
            r_miss      <= '0;
            r_shadow    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_lane      <= w_lane_nxt;
            r_miss      <= w_miss_nxt;
            r_shadow    <= w_shadow_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_sync_err  <= w_sync_err_nxt;
            r_overrun   <= w_overrun_nxt;
`ifdef PARITY_CHECK_EN
            r_par_err   <= w_par_err_nxt;
`endif
        end
    end

    // Next-state: lock tracking, slot routing and frame hand-off.
    always_comb begin
        w_state_nxt     = r_state;
        w_lane_nxt      = r_lane;
        w_miss_nxt      = r_miss;
        w_shadow_nxt    = r_shadow;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid & ~bus.out_ready;
        w_sync_err_nxt  = 1'b0;
        w_overrun_nxt   = 1'b0;
        w_frame_ok      = 1'b1;
`ifdef PARITY_CHECK_EN
        w_par_err_nxt   = 1'b0;
`endif

        case (r_state)
            HUNT: begin
                if (bus.in_valid && bus.in_sync) begin
                    w_shadow_nxt              = '0;
                    w_shadow_nxt[0 +: SLOT_W] = bus.in_data;
                    w_lane_nxt                = LANE_W'(1);
                    w_miss_nxt                = '0;
                    w_state_nxt               = LOCK;
                end
            end
            LOCK: begin
                if (bus.in_valid) begin
                    if (bus.in_sync && (r_lane != '0)) begin
                        // Early sync restarts the frame from this sample.
                        w_sync_err_nxt            = 1'b1;
                        w_shadow_nxt              = '0;
                        w_shadow_nxt[0 +: SLOT_W] = bus.in_data;
                        w_lane_nxt                = LANE_W'(1);
                        w_miss_nxt                = w_miss_inc;
                        if (w_miss_inc >= MISS_LIM) begin
                            w_state_nxt = HUNT;
                            w_lane_nxt  = '0;
                            w_miss_nxt  = '0;
                        end
                    end else if (!bus.in_sync && (r_lane == '0)) begin
                        w_sync_err_nxt = 1'b1;
                        w_miss_nxt     = w_miss_inc;
                        if (w_miss_inc >= MISS_LIM) begin
                            w_state_nxt = HUNT;
                            w_miss_nxt  = '0;
                        end
                    end else begin
                        for (int i = 0; i < int'(LANES); i++) begin
                            if (r_lane == LANE_W'(i)) begin
                                w_shadow_nxt[i*SLOT_W +: SLOT_W] = bus.in_data;
                            end
                        end
                        if (r_lane == LAST_SLOT) begin
                            w_lane_nxt = '0;
`ifdef PARITY_CHECK_EN
                            w_frame_ok    = (w_parity == bus.in_data);
                            w_par_err_nxt = ~w_frame_ok;
`endif
                            if (w_frame_ok) begin
                                w_miss_nxt = '0;
                                if (!r_out_valid || bus.out_ready) begin
                                    w_out_data_nxt  = w_shadow_nxt;
                                    w_out_valid_nxt = 1'b1;
                                end else begin
                                    w_overrun_nxt = 1'b1;
                                end
                            end
                        end else begin
                            w_lane_nxt = r_lane + LANE_W'(1);
                        end
                    end
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    // With the parity slot enabled, slot index 8 reads back as 0 on the 3-bit port.
    assign bus.lane_sel  = r_lane[2:0];
    assign bus.locked    = (r_state == LOCK);
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.sync_err  = r_sync_err;
    assign bus.overrun   = r_overrun;
`ifdef PARITY_CHECK_EN
    assign bus.par_err   = r_par_err;
`else
    assign bus.par_err   = 1'b0;
`endif
endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Directed bench for tdm_demux_1x8 (SLOT_W=1, SYNC_LOSS_MAX=3); parity test when PARITY_CHECK_EN is set.
module tb_tdm_demux_1x8;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    tdm_demux_1x8_if #(.SLOT_W(1)) bus ();

    tdm_demux_1x8 #(.SLOT_W(1), .SYNC_LOSS_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One valid sample, returning 1 time unit after the edge that took it.
    task automatic send_slot(input logic s, input logic d);
        bus.in_valid = 1'b1;
        bus.in_sync  = s;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_data  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_slot(i == 0, b[i]);
`ifdef PARITY_CHECK_EN
        send_slot(1'b0, ^b);
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_sync = 1'b0; bus.in_data = 1'b0; bus.out_ready = 1'b0;
        idle(2);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        if ({bus.out_valid, bus.locked, bus.sync_err, bus.overrun, bus.par_err} !== 5'b0) begin
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.out_valid, bus.locked, bus.sync_err, bus.overrun, bus.par_err});
            n_fail++;
        end
        n_checks++;
        if (bus.out_data !== 8'h00 || bus.lane_sel !== 3'd0) begin
            $display("FAIL reset_data: got data=%h lane=%0d expected 00/0", bus.out_data, bus.lane_sel);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_hunt;
        for (int i = 0; i < 5; i++) send_slot(1'b0, 1'b1);
        if (bus.locked !== 1'b0 || bus.out_valid !== 1'b0 || bus.lane_sel !== 3'd0) begin
            $display("FAIL hunt_discard: got locked=%b valid=%b lane=%0d expected 0/0/0",
                     bus.locked, bus.out_valid, bus.lane_sel);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_basic;
        bus.out_ready = 1'b1;
        send_frame(8'h4D);
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h4D) begin
            $display("FAIL basic_frame: got valid=%b data=%h expected 1/4d", bus.out_valid, bus.out_data);
            n_fail++;
        end
        n_checks++;
        if (bus.locked !== 1'b1 || bus.lane_sel !== 3'd0) begin
            $display("FAIL basic_lock: got locked=%b lane=%0d expected 1/0", bus.locked, bus.lane_sel);
            n_fail++;
        end
        n_checks++;
        idle(1);
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL basic_valid_drop: got %b expected 0", bus.out_valid);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_stall;
        logic [7:0] b;
        b = 8'h4D;
        for (int i = 0; i < 8; i++) begin
            send_slot(i == 0, b[i]);
            idle(2);
            if (bus.lane_sel !== 3'(i + 1)) begin
                $display("FAIL stall_lane%0d: got %0d expected %0d", i, bus.lane_sel, 3'(i + 1));
                n_fail++;
            end
            n_checks++;
        end
`ifdef PARITY_CHECK_EN
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL stall_early_valid: got %b expected 0", bus.out_valid);
            n_fail++;
        end
        n_checks++;
        send_slot(1'b0, ^b);
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h4D) begin
            $display("FAIL stall_frame: got valid=%b data=%h expected 1/4d", bus.out_valid, bus.out_data);
            n_fail++;
        end
        n_checks++;
`else
        // After two idle cycles the frame was accepted with out_ready high, so out_valid has cleared.
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h4D) begin
            $display("FAIL stall_frame: got valid=%b data=%h expected 0/4d", bus.out_valid, bus.out_data);
            n_fail++;
        end
        n_checks++;
`endif
        idle(1);
    endtask

    task automatic test_overrun;
        bus.out_ready = 1'b0;
        send_frame(8'hA5);
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.overrun !== 1'b0) begin
            $display("FAIL ovr_first: got valid=%b data=%h ovr=%b expected 1/a5/0",
                     bus.out_valid, bus.out_data, bus.overrun);
            n_fail++;
        end
        n_checks++;
        send_frame(8'h3C);
        if (bus.overrun !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_valid !== 1'b1) begin
            $display("FAIL ovr_pulse: got ovr=%b data=%h valid=%b expected 1/a5/1",
                     bus.overrun, bus.out_data, bus.out_valid);
            n_fail++;
        end
        n_checks++;
        idle(1);
        if (bus.overrun !== 1'b0) begin
            $display("FAIL ovr_single: got %b expected 0", bus.overrun);
            n_fail++;
        end
        n_checks++;
        bus.out_ready = 1'b1;
        idle(1);
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'hA5) begin
            $display("FAIL ovr_drain: got valid=%b data=%h expected 0/a5", bus.out_valid, bus.out_data);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_misplaced_sync;
        logic [7:0] b;
        b = 8'h3C;
        send_slot(1'b1, 1'b1); send_slot(1'b0, 1'b0); send_slot(1'b0, 1'b1); send_slot(1'b0, 1'b1);
        send_slot(1'b1, b[0]);
        if (bus.sync_err !== 1'b1 || bus.lane_sel !== 3'd1 || bus.locked !== 1'b1) begin
            $display("FAIL misplaced_sync: got err=%b lane=%0d locked=%b expected 1/1/1",
                     bus.sync_err, bus.lane_sel, bus.locked);
            n_fail++;
        end
        n_checks++;
        for (int i = 1; i < 8; i++) send_slot(1'b0, b[i]);
`ifdef PARITY_CHECK_EN
        send_slot(1'b0, ^b);
`endif
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.sync_err !== 1'b0) begin
            $display("FAIL misplaced_recover: got valid=%b data=%h err=%b expected 1/3c/0",
                     bus.out_valid, bus.out_data, bus.sync_err);
            n_fail++;
        end
        n_checks++;
        idle(1);
    endtask

    task automatic test_missing_sync;
        send_slot(1'b0, 1'b1);
        if (bus.sync_err !== 1'b1 || bus.lane_sel !== 3'd0 || bus.locked !== 1'b1) begin
            $display("FAIL missing_sync: got err=%b lane=%0d locked=%b expected 1/0/1",
                     bus.sync_err, bus.lane_sel, bus.locked);
            n_fail++;
        end
        n_checks++;
        send_frame(8'h96);
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h96) begin
            $display("FAIL missing_recover: got valid=%b data=%h expected 1/96", bus.out_valid, bus.out_data);
            n_fail++;
        end
        n_checks++;
        idle(1);
    endtask

    task automatic test_sync_loss;
        send_slot(1'b1, 1'b0); send_slot(1'b0, 1'b0); send_slot(1'b0, 1'b0); send_slot(1'b0, 1'b0);
        send_slot(1'b1, 1'b0);
        send_slot(1'b0, 1'b0); send_slot(1'b0, 1'b0);
        send_slot(1'b1, 1'b0);
        if (bus.sync_err !== 1'b1 || bus.locked !== 1'b1) begin
            $display("FAIL loss_second_miss: got err=%b locked=%b expected 1/1", bus.sync_err, bus.locked);
            n_fail++;
        end
        n_checks++;
        send_slot(1'b0, 1'b0);
        send_slot(1'b1, 1'b0);
        if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || bus.lane_sel !== 3'd0) begin
            $display("FAIL loss_third_miss: got err=%b locked=%b lane=%0d expected 1/0/0",
                     bus.sync_err, bus.locked, bus.lane_sel);
            n_fail++;
        end
        n_checks++;
        send_slot(1'b0, 1'b1);
        if (bus.sync_err !== 1'b0 || bus.locked !== 1'b0) begin
            $display("FAIL loss_hunt_quiet: got err=%b locked=%b expected 0/0", bus.sync_err, bus.locked);
            n_fail++;
        end
        n_checks++;
        send_frame(8'h5A);
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A) begin
            $display("FAIL loss_relock: got valid=%b data=%h expected 1/5a", bus.out_valid, bus.out_data);
            n_fail++;
        end
        n_checks++;
        idle(1);
    endtask

    task automatic test_reset_midframe;
        bus.out_ready = 1'b0;
        send_frame(8'hC3);
        send_slot(1'b1, 1'b1); send_slot(1'b0, 1'b1); send_slot(1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        if (bus.out_valid !== 1'b0 || bus.locked !== 1'b0 || bus.lane_sel !== 3'd0 || bus.out_data !== 8'h00) begin
            $display("FAIL rst_async: got valid=%b locked=%b lane=%0d data=%h expected 0/0/0/00",
                     bus.out_valid, bus.locked, bus.lane_sel, bus.out_data);
            n_fail++;
        end
        n_checks++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send_frame(8'h4D);
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h4D) begin
            $display("FAIL rst_clean_frame: got valid=%b data=%h expected 1/4d", bus.out_valid, bus.out_data);
            n_fail++;
        end
        n_checks++;
        idle(1);
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity;
        logic [7:0] b;
        b = 8'h4D;
        for (int i = 0; i < 8; i++) send_slot(i == 0, b[i]);
        send_slot(1'b0, 1'b0);
        if (bus.out_valid !== 1'b1 || bus.par_err !== 1'b0 || bus.out_data !== 8'h4D) begin
            $display("FAIL parity_good: got valid=%b perr=%b data=%h expected 1/0/4d",
                     bus.out_valid, bus.par_err, bus.out_data);
            n_fail++;
        end
        n_checks++;
        idle(1);
        for (int i = 0; i < 8; i++) send_slot(i == 0, b[i]);
        send_slot(1'b0, 1'b1);
        if (bus.out_valid !== 1'b0 || bus.par_err !== 1'b1 || bus.overrun !== 1'b0) begin
            $display("FAIL parity_bad: got valid=%b perr=%b ovr=%b expected 0/1/0",
                     bus.out_valid, bus.par_err, bus.overrun);
            n_fail++;
        end
        n_checks++;
        idle(1);
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_hunt();
        test_basic();
        test_stall();
        test_overrun();
        test_misplaced_sync();
        test_missing_sync();
        test_sync_loss();
        test_reset_midframe();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
